// File: rtl/reg_port_arbiter.sv
// Two-port arbiter in front of the shared register-bank access port.
// Port 0 is the AXI-lite host CSR path and port 1 is the AES status/debug engine.
// The arbiter grants the ports in round-robin order and issues one strobe per grant.
// Read data comes back a fixed number of cycles after the strobe and is returned
// with a one-cycle ack to the port that made the request.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no access in flight; arbitrate between the pending requests
// S_ISSUE | drive reg_write or reg_read for one cycle with latched addr/data
// S_WAIT  | count down the read latency; capture reg_rdata when count is 1
// S_ACK   | pulse the granted port's ack, with read data for reads
module reg_port_arbiter #(
   parameter int C_ADDR_WIDTH = 10,
   parameter int C_DATA_WIDTH = 32,
   parameter int C_RD_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    m0_req,
   input  logic                    m0_we,
   input  logic [C_ADDR_WIDTH-1:0] m0_addr,
   input  logic [C_DATA_WIDTH-1:0] m0_wdata,
   output logic                    m0_ack,
   output logic [C_DATA_WIDTH-1:0] m0_rdata,
   input  logic                    m1_req,
   input  logic                    m1_we,
   input  logic [C_ADDR_WIDTH-1:0] m1_addr,
   input  logic [C_DATA_WIDTH-1:0] m1_wdata,
   output logic                    m1_ack,
   output logic [C_DATA_WIDTH-1:0] m1_rdata,
   output logic [C_ADDR_WIDTH-1:0] reg_addr,
   output logic                    reg_write,
   output logic [C_DATA_WIDTH-1:0] reg_wdata,
   output logic                    reg_read,
   input  logic [C_DATA_WIDTH-1:0] reg_rdata,
   output logic                    busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   // Three bits are enough for the supported latency range of 1..7.
   localparam logic [2:0] LAT_INIT = 3'(C_RD_LATENCY);

   state_t                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic                    grant_q, grant_d;
   logic                    we_q, we_d;
   logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                    busy_q, busy_d;

   // State and datapath registers. The reset value of last_grant makes port 0 win the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, issue the access, time the read, then acknowledge.
   always_comb begin
      logic gsel;
      gsel         = 1'b0;
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (m0_req || m1_req) begin
               if (m0_req && m1_req) gsel = ~last_grant_q;
               else                  gsel = m1_req;
               grant_d      = gsel;
               last_grant_d = gsel;
               we_d         = gsel ? m1_we    : m0_we;
               addr_d       = gsel ? m1_addr  : m0_addr;
               wdata_d      = gsel ? m1_wdata : m0_wdata;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d = S_ACK;
            end else begin
               cnt_d   = LAT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               rdata_d = reg_rdata;
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Output decode from the registered state. The latched address and data are held between strobes.
   always_comb begin
      reg_addr  = addr_q;
      reg_wdata = wdata_q;
      reg_write = (state_q == S_ISSUE) &&  we_q;
      reg_read  = (state_q == S_ISSUE) && !we_q;
      m0_ack    = (state_q == S_ACK) && !grant_q;
      m1_ack    = (state_q == S_ACK) &&  grant_q;
      m0_rdata  = (m0_ack && !we_q) ? rdata_q : '0;
      m1_rdata  = (m1_ack && !we_q) ? rdata_q : '0;
      busy      = busy_q;
   end

endmodule
